// File: rtl/init_seq_ctrl_if.sv
// Handshake/config bus between the clock manager, config port and init_seq_ctrl.
// ack/err exist only when INIT_ACK_EN is defined.
interface init_seq_ctrl_if #(parameter int NCH = 4);
  logic              locked, reinit, cfg_wr;
  logic [3:0]        cfg_ch;
  logic [15:0]       cfg_word;
  logic [NCH-1:0]    latch_baud;
  logic [NCH*16-1:0] baud_word;
  logic              busy, done;
`ifdef INIT_ACK_EN
  logic [NCH-1:0]    ack, err;
  modport master (output locked, reinit, cfg_wr, cfg_ch, cfg_word, ack,
                  input  latch_baud, baud_word, busy, done, err);
  modport slave  (input  locked, reinit, cfg_wr, cfg_ch, cfg_word, ack,
                  output latch_baud, baud_word, busy, done, err);
`else
  modport master (output locked, reinit, cfg_wr, cfg_ch, cfg_word,
                  input  latch_baud, baud_word, busy, done);
  modport slave  (input  locked, reinit, cfg_wr, cfg_ch, cfg_word,
                  output latch_baud, baud_word, busy, done);
`endif
endinterface

// File: rtl/init_seq_ctrl.sv
// Power-up sequencer: waits for lock, strobes per-channel baud words with a gap, settles, raises done.
// Optional INIT_ACK_EN: per-channel ack wait with timeout and err flags.
module init_seq_ctrl #(
  parameter int NCH      = 4,
  parameter int CW       = 16,
  parameter int INIT_ST  = 1000,
  parameter int GAP      = 16,
  parameter int WAIT_LEN = 32728,
  parameter logic [NCH*16-1:0] BAUD_INIT = {NCH{16'd2}}
`ifdef INIT_ACK_EN
  , parameter int ACK_TO = 256
`endif
) (
  input  logic          clk,
  input  logic          rst,
  init_seq_ctrl_if.slave bus
);
  localparam int              CHW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   INIT_LAST = CW'(INIT_ST - 1);
  localparam logic [CW-1:0]   GAP_LAST  = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [CW-1:0]   SETL_LAST = CW'(WAIT_LEN - 1);
  localparam logic [CHW-1:0]  CH_LAST   = CHW'(NCH - 1);
  localparam logic [4:0]      NCH5      = 5'(NCH);

  typedef enum logic [2:0] {
    IDLE, WAIT_ST, LATCH, GAP_S, SETTLE, DONE
`ifdef INIT_ACK_EN
    , ACK_WAIT
`endif
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_tcnt;
  logic [CHW-1:0]        r_ch;
  logic [1:0]            r_sync;
  logic                  r_lock_d;
  logic [NCH-1:0]        r_latch;
  logic [NCH-1:0][15:0]  r_baud, r_shadow;
  logic                  r_busy, r_done;
  logic                  w_locked_s, w_rise, w_fall, w_trig, w_step, w_last;
  logic [CHW-1:0]        w_nch;

  assign w_locked_s = r_sync[1];
  assign w_rise     = w_locked_s & ~r_lock_d;
  assign w_fall     = ~w_locked_s & r_lock_d;
  assign w_trig     = w_rise | (bus.reinit & w_locked_s);
  assign w_last     = (r_ch == CH_LAST);
  assign w_nch      = r_ch + CHW'(1);

`ifdef INIT_ACK_EN
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);
  logic [NCH-1:0] r_err;
  logic           w_ack_to;
  assign w_ack_to = (r_state == ACK_WAIT) && (r_tcnt == ACK_LAST) && !bus.ack[r_ch];
  assign w_step   = (r_state == ACK_WAIT) && (bus.ack[r_ch] || (r_tcnt == ACK_LAST));
  assign bus.err  = r_err;
`else
  assign w_step   = (r_state == LATCH);
`endif

  // Shadow is written at the same edge baud_word samples it, so a colliding write lands next sequence.
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      r_shadow <= BAUD_INIT;
    else if (bus.cfg_wr && ({1'b0, bus.cfg_ch} < NCH5))
      r_shadow[bus.cfg_ch[CHW-1:0]] <= bus.cfg_word;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= IDLE;
      r_tcnt   <= '0;
      r_ch     <= '0;
      r_sync   <= '0;
      r_lock_d <= 1'b0;
      r_latch  <= '0;
      r_baud   <= BAUD_INIT;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef INIT_ACK_EN
      r_err    <= '0;
`endif
    end else begin
      r_sync   <= {r_sync[0], bus.locked};
      r_lock_d <= w_locked_s;
      if (w_fall) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_latch <= '0;
      end else if (w_trig) begin
        r_state <= WAIT_ST;
        r_tcnt  <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_latch <= '0;
`ifdef INIT_ACK_EN
        r_err   <= '0;
`endif
      end else begin
        r_latch <= '0;
        r_tcnt  <= r_tcnt + CW'(1);
        case (r_state)
          WAIT_ST: if (r_tcnt == INIT_LAST) begin
            r_state   <= LATCH;
            r_ch      <= '0;
            r_latch   <= NCH'(1);
            r_baud[0] <= r_shadow[0];
          end
          GAP_S: if (r_tcnt == GAP_LAST) begin
            r_state       <= LATCH;
            r_ch          <= w_nch;
            r_latch       <= NCH'(1) << w_nch;
            r_baud[w_nch] <= r_shadow[w_nch];
          end
          SETTLE: if (r_tcnt == SETL_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
`ifdef INIT_ACK_EN
          LATCH: begin
            r_state <= ACK_WAIT;
            r_tcnt  <= '0;
          end
          ACK_WAIT: if (w_ack_to) r_err[r_ch] <= 1'b1;
`endif
          default: ;
        endcase
        // Channel finished: next gap, next strobe (zero gap) or settle.
        if (w_step) begin
          r_tcnt <= '0;
          if (w_last)
            r_state <= SETTLE;
          else if (GAP == 0) begin
            r_state       <= LATCH;
            r_ch          <= w_nch;
            r_latch       <= NCH'(1) << w_nch;
            r_baud[w_nch] <= r_shadow[w_nch];
          end else
            r_state <= GAP_S;
        end
      end
    end

  assign bus.latch_baud = r_latch;
  assign bus.baud_word  = r_baud;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_init_seq_ctrl.sv
// Directed bench for init_seq_ctrl: GAP=3 and GAP=0 instances run side by side.
module tb_init_seq_ctrl;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  init_seq_ctrl_if #(.NCH(NCH)) if0 ();
  init_seq_ctrl_if #(.NCH(NCH)) if1 ();

  init_seq_ctrl #(.NCH(NCH), .INIT_ST(10), .GAP(3), .WAIT_LEN(20)
`ifdef INIT_ACK_EN
    , .ACK_TO(8)
`endif
  ) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  init_seq_ctrl #(.NCH(NCH), .INIT_ST(10), .GAP(0), .WAIT_LEN(20)
`ifdef INIT_ACK_EN
    , .ACK_TO(8)
`endif
  ) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

`ifdef INIT_ACK_EN
  // Responder acks every channel one cycle after its strobe, except channel 1.
  logic [NCH-1:0] ack0 = '0, ack1 = '0;
  always @(posedge clk) begin
    ack0 <= if0.latch_baud & 4'b1101;
    ack1 <= if1.latch_baud & 4'b1101;
  end
  assign if0.ack = ack0;
  assign if1.ack = ack1;
`endif

  typedef struct {
    int          t;
    logic [3:0]  lb0; logic bz0; logic dn0;
    logic [3:0]  lb1; logic bz1; logic dn1;
    logic        wr;  logic [3:0] ch; logic [15:0] wd;
  } vec_t;

  vec_t tbl[15];
  int   nvec = 0, nerr = 0, cyc = 0;
  int   sc0[NCH], sc1[NCH];
  logic lk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ri, input logic wr, input logic [3:0] ch, input logic [15:0] wd);
    if0.locked = lk; if1.locked = lk;
    if0.reinit = ri; if1.reinit = ri;
    if0.cfg_wr = wr; if1.cfg_wr = wr;
    if0.cfg_ch = ch; if1.cfg_ch = ch;
    if0.cfg_word = wd; if1.cfg_word = wd;
  endtask

  // One clock: tally strobes seen in the current cycle, advance, drop one-cycle pulses.
  task automatic step();
    for (int k = 0; k < NCH; k++) begin
      sc0[k] += int'(if0.latch_baud[k]);
      sc1[k] += int'(if1.latch_baud[k]);
    end
    @(posedge clk); #1;
    cyc++;
    drv(1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic clr_sc();
    for (int k = 0; k < NCH; k++) begin sc0[k] = 0; sc1[k] = 0; end
  endtask

  function automatic logic [63:0] scv(input int a[NCH]);
    logic [63:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k*16 +: 16] = 16'(a[k]);
    return v;
  endfunction

  initial begin
    tbl[0]  = '{0,  4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[1]  = '{9,  4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[2]  = '{10, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[3]  = '{11, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[4]  = '{12, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[5]  = '{13, 4'h0, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[6]  = '{14, 4'h2, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[7]  = '{18, 4'h4, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[8]  = '{22, 4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[9]  = '{23, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0};
    tbl[10] = '{30, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0010};
    tbl[11] = '{33, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'd5, 16'hBEEF};
    tbl[12] = '{34, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0};
    tbl[13] = '{42, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0};
    tbl[14] = '{43, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0};

    drv(1'b0, 1'b0, 4'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctl0", {if0.latch_baud, if0.busy, if0.done}, '0);
    chk("reset baud0", if0.baud_word, {4{16'd2}});
    rst = 1'b1;
    repeat (3) step();
    chk("idle unlocked", {if0.busy, if1.busy}, '0);

`ifdef INIT_ACK_EN
    chk("reset err", {if0.err, if1.err}, '0);
    lk = 1'b1; drv(1'b0, 1'b0, 4'd0, 16'd0);
    repeat (3) step();
    cyc = 0;
    step_to(23); chk("err before timeout", if0.err, 4'b0000);
    step_to(24); chk("err after timeout", if0.err, 4'b0010);
    step_to(45); chk("ack gap0 done", {if1.err, if1.done}, {4'b0010, 1'b1});
    step_to(53); chk("ack done early", if0.done, 1'b0);
    step_to(54); chk("ack done", {if0.done, if0.busy}, 2'b10);
`else
    // Basic sequence from a lock edge.
    lk = 1'b1; drv(1'b0, 1'b0, 4'd0, 16'd0);
    step(); step();
    chk("pre-trigger busy", if0.busy, 1'b0);
    step();
    cyc = 0;
    clr_sc();
    for (int i = 0; i < 15; i++) begin
      step_to(tbl[i].t);
      chk($sformatf("tbl t=%0d", tbl[i].t),
          {if0.latch_baud, if0.busy, if0.done, if1.latch_baud, if1.busy, if1.done},
          {tbl[i].lb0, tbl[i].bz0, tbl[i].dn0, tbl[i].lb1, tbl[i].bz1, tbl[i].dn1});
      if (tbl[i].wr) drv(1'b0, 1'b1, tbl[i].ch, tbl[i].wd);
    end
    chk("strobe count gap3", scv(sc0), {4{16'd1}});
    chk("strobe count gap0", scv(sc1), {4{16'd1}});
    chk("baud after seq1", if0.baud_word, {4{16'd2}});

    // Reinit picks up the shadow write; colliding write keeps the old word.
    step_to(45);
    drv(1'b1, 1'b0, 4'd0, 16'd0);
    step();
    cyc = 0;
    chk("reinit clears done", {if0.done, if0.busy, if1.done, if1.busy}, 4'b0101);
    step_to(12); chk("gap0 ch2 word", {if1.latch_baud, if1.baud_word[47:32]}, {4'h4, 16'h0010});
    step_to(17); chk("ch2 old word", if0.baud_word[47:32], 16'h0002);
    step_to(18); chk("ch2 new word", {if0.latch_baud, if0.baud_word}, {4'h4, 16'h2, 16'h0010, 16'h2, 16'h2});
    step_to(21); drv(1'b0, 1'b1, 4'd3, 16'h0033);
    step();
    chk("collide write", {if0.latch_baud, if0.baud_word[63:48]}, {4'h8, 16'h0002});

    // Lock loss mid-sequence.
    drv(1'b1, 1'b0, 4'd0, 16'd0);
    step();
    cyc = 0;
    step_to(16); lk = 1'b0; drv(1'b0, 1'b0, 4'd0, 16'd0);
    step_to(19);
    chk("lock loss idle", {if0.latch_baud, if0.busy, if0.done, if1.busy}, '0);
    chk("lock loss holds baud", if0.baud_word, {16'h2, 16'h0010, 16'h2, 16'h2});
    clr_sc();
    step_to(40);
    chk("no strobes unlocked", scv(sc0) | scv(sc1), '0);
    lk = 1'b1; drv(1'b0, 1'b0, 4'd0, 16'd0);
    repeat (3) step();
    cyc = 0;
    step_to(22); chk("relock ch3", {if0.latch_baud, if0.baud_word}, {4'h8, 16'h0033, 16'h0010, 16'h2, 16'h2});
    step_to(43); chk("relock done", {if0.done, if0.busy}, 2'b10);

    // Reinit ignored while unlocked.
    lk = 1'b0; drv(1'b0, 1'b0, 4'd0, 16'd0);
    repeat (4) step();
    chk("unlock clears done", {if0.done, if1.done}, 2'b00);
    drv(1'b1, 1'b0, 4'd0, 16'd0);
    begin
      logic seen = 1'b0;
      repeat (6) begin step(); seen |= if0.busy | if1.busy; end
      chk("reinit unlocked ignored", seen, 1'b0);
    end

    // Out-of-range channel write had no effect; async reset mid-gap.
    lk = 1'b1; drv(1'b0, 1'b0, 4'd0, 16'd0);
    repeat (3) step();
    cyc = 0;
    step_to(23); chk("cfg_ch 5 ignored", if0.baud_word, {16'h0033, 16'h0010, 16'h2, 16'h2});
    drv(1'b1, 1'b0, 4'd0, 16'd0);
    step();
    cyc = 0;
    step_to(12); chk("mid gap busy", if0.busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("async reset ctl", {if0.latch_baud, if0.busy, if0.done, if1.latch_baud, if1.busy, if1.done}, '0);
    chk("async reset baud", if0.baud_word, {4{16'd2}});
    rst = 1'b1;
    repeat (3) step();
    cyc = 0;
    step_to(18); chk("shadow reset", {if0.latch_baud, if0.baud_word[47:32]}, {4'h4, 16'h0002});
    step_to(43); chk("post-reset done", {if0.done, if0.busy}, 2'b10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/init_seq_ctrl.md
Name: init_seq_ctrl

Overview:
Parametrised power-up initialisation sequencer for NCH UART/peripheral channels. It waits for the clock-manager lock, then issues one-cycle latch strobes with per-channel baud words, staggered by a programmable gap. After a settle interval it raises done. Lock loss or a reinit request restarts the sequence. Baud words are runtime-overridable through a small config write port and sit between the clock manager and the UART baud generators.

Parameters:
NCH, 4, number of channels (1..16)
CW, 16, width of the internal interval counter
INIT_ST, 1000, cycles from sequence start to the latch_baud[0] strobe (>=1)
GAP, 16, idle cycles between consecutive channel strobes (>=0)
WAIT_LEN, 32728, settle cycles after the last strobe before done (>=1)
BAUD_INIT, {NCH{16'd2}}, packed NCH*16 reset/default baud words; channel k in bits [16k+15:16k]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
locked  in  1  clock-manager lock, asynchronous, synchronised internally
reinit  in  1  one-cycle request to rerun the sequence
cfg_wr  in  1  shadow baud word write strobe
cfg_ch  in  4  channel index for cfg_wr
cfg_word  in  16  baud word written on cfg_wr
latch_baud  out  NCH  per-channel one-cycle latch strobe
baud_word  out  NCH*16  packed per-channel baud words
busy  out  1  sequence in progress
done  out  1  initialisation complete

Behaviour:
- Reset values: latch_baud=0, baud_word=BAUD_INIT, busy=0, done=0, state=IDLE. Shadow words are reset to BAUD_INIT. The 2-FF locked synchroniser and the edge-detect register are reset to 0.
- Trigger: a rising edge of synchronised locked (locked_s), or reinit=1 while locked_s=1. locked held high through reset release counts as a rising edge. reinit while locked_s=0 is ignored.
- A trigger in any state clears done, zeroes latch_baud and enters WAIT_ST. Cycle 0 is the first cycle in WAIT_ST.
- A falling edge of locked_s in any state goes to IDLE with busy=0, done=0, latch_baud=0. baud_word holds its value.
- Each timed state lasts N cycles. tcnt clears on entry; the state exits when tcnt==N-1.
- States:
  - IDLE: waits for a trigger.
  - WAIT_ST: INIT_ST cycles, then LATCH with ch=0.
  - LATCH: 1 cycle, latch_baud[ch]=1. Goes to GAP (or straight to LATCH ch+1 if GAP=0); after ch==NCH-1 goes to SETTLE.
  - GAP: GAP cycles, then LATCH ch+1.
  - SETTLE: WAIT_LEN cycles, then DONE.
  - DONE: done=1, holds until trigger or lock loss.
- Timing:
  - latch_baud[k] is high in cycle INIT_ST+k*(GAP+1), exactly one cycle, one-hot.
  - done rises in cycle INIT_ST+(NCH-1)*(GAP+1)+1+WAIT_LEN.
- baud_word[k] loads shadow[k] at the same clock edge that raises latch_baud[k]. The word is therefore valid in the strobe cycle and held until the next strobe of k.
- cfg_wr writes shadow[cfg_ch] in any state; cfg_ch>=NCH is ignored. A write in the same cycle the shadow is sampled for that channel's strobe takes effect on the next sequence only (old value used).
- busy=1 in WAIT_ST/LATCH/GAP/SETTLE (and ACK_WAIT), else 0. All outputs are registered.

Optional Feature:
INIT_ACK_EN:
- Adds input ack[NCH], output err[NCH] (reset 0), and parameter ACK_TO (default 256).
- After LATCH of channel ch, enter ACK_WAIT. An ack[ch] pulse proceeds to GAP/SETTLE on the next cycle. After ACK_TO cycles without ack, set err[ch]=1 and proceed anyway.
- err clears on trigger. With ack, strobe timings above shift by the ack latency.
- Without the macro: no ack/err ports and no ACK_WAIT state; timing exactly as above.

Test Plan:
Bench overrides are NCH=4, INIT_ST=10, GAP=3, WAIT_LEN=20; locked is asserted after reset.
1. Basic sequence -> latch_baud[0..3] strobes 1 cycle each at cycles 10/14/18/22, all baud_word=16'd2, done rises at cycle 43, busy high cycles 0..42.
2. cfg_wr ch2=16'h0010 during SETTLE, then reinit -> done drops, baud_word[2] becomes 0x0010 in the latch_baud[2] strobe cycle, others stay 2.
3. Deassert locked at cycle 16 -> IDLE, busy=0, no further strobes. Reassert -> full sequence restarts from cycle 0.
4. GAP=0 override -> strobes at consecutive cycles 10..13, done at cycle 34. reinit with locked low -> no effect.
5. cfg_ch=5 with NCH=4 -> no word changes. Reset asserted mid-GAP -> all outputs return to reset values asynchronously.
6. INIT_ACK_EN, ACK_TO=8, ack withheld on ch1 -> err=4'b0010 after 8 cycles, sequence completes, done=1.
